// File: rtl/ps2_key_encoder.sv
// PS/2 device-to-host receiver: synchronise, glitch-filter, frame, decode prefixes, publish toggle-strobed key word.
// Optional build macro: PS2_TYPEMATIC_FILTER_EN suppresses repeated makes of the same key.
module ps2_key_encoder #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 48000
) (
    input  logic        I_CLK_48M,
    input  logic        I_RESETn,
    input  logic        I_PS2_CLK,
    input  logic        I_PS2_DAT,
    output logic [10:0] O_PS2_KEY,
    output logic        O_STROBE,
    output logic        O_ERR
);

    // state    | meaning
    // S_IDLE   | waiting for a start bit (sample 0)
    // S_DATA   | shifting 8 data bits, LSB first
    // S_PARITY | sampling odd-parity bit
    // S_STOP   | sampling stop bit, byte accepted or rejected
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    localparam logic [7:0]  FLT_TC = 8'(FILTER_LEN - 1);
    localparam logic [16:0] TO_TC  = 17'(TIMEOUT);

    logic [1:0]  clk_sync_q, dat_sync_q;
    logic        clk_flt_q, clk_flt_d;
    logic        dat_flt_q, dat_flt_d;
    logic [7:0]  clk_cnt_q, clk_cnt_d;
    logic [7:0]  dat_cnt_q, dat_cnt_d;
    logic        clk_prev_q;

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic        par_err_q, par_err_d;
    logic [16:0] to_cnt_q, to_cnt_d;

    logic        ext_q, ext_d;
    logic        brk_q, brk_d;
    logic        skip_q, skip_d;
    logic [2:0]  skip_cnt_q, skip_cnt_d;
    logic [10:0] key_q, key_d;
    logic        strobe_q, strobe_d;
    logic        err_q, err_d;

    logic        fall;
    logic        byte_vld;
    logic        frame_err;

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic        tm_vld_q, tm_vld_d;
    logic [8:0]  tm_key_q, tm_key_d;
`endif

    // Glitch filter: the filtered level follows only after FILTER_LEN steady cycles of a new level.
    always_comb begin
        clk_flt_d = clk_flt_q;
        clk_cnt_d = '0;
        dat_flt_d = dat_flt_q;
        dat_cnt_d = '0;
        if (clk_sync_q[1] != clk_flt_q) begin
            if (clk_cnt_q == FLT_TC) begin
                clk_flt_d = clk_sync_q[1];
            end else begin
                clk_cnt_d = clk_cnt_q + 8'd1;
            end
        end
        if (dat_sync_q[1] != dat_flt_q) begin
            if (dat_cnt_q == FLT_TC) begin
                dat_flt_d = dat_sync_q[1];
            end else begin
                dat_cnt_d = dat_cnt_q + 8'd1;
            end
        end
    end

    assign fall = clk_prev_q & ~clk_flt_q;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        par_err_d = par_err_q;
        byte_vld  = 1'b0;
        frame_err = 1'b0;
        to_cnt_d  = (fall || state_q == S_IDLE) ? '0 : to_cnt_q + 17'd1;

        case (state_q)
            S_IDLE: begin
                if (fall && !dat_flt_q) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                    par_d     = 1'b0;
                end
            end
            S_DATA: begin
                if (fall) begin
                    shift_d   = {dat_flt_q, shift_q[7:1]};
                    par_d     = par_q ^ dat_flt_q;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (fall) begin
                    par_err_d = ~(par_q ^ dat_flt_q);
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (fall) begin
                    state_d = S_IDLE;
                    if (dat_flt_q && !par_err_q) begin
                        byte_vld = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Timeout only fires in a cycle without a falling edge, so it never collides with a stop sample.
        if (state_q != S_IDLE && !fall && to_cnt_q == TO_TC) begin
            state_d   = S_IDLE;
            frame_err = 1'b1;
        end
    end

    always_comb begin
        ext_d      = ext_q;
        brk_d      = brk_q;
        skip_d     = skip_q;
        skip_cnt_d = skip_cnt_q;
        key_d      = key_q;
        strobe_d   = 1'b0;
        err_d      = frame_err;
`ifdef PS2_TYPEMATIC_FILTER_EN
        tm_vld_d   = tm_vld_q;
        tm_key_d   = tm_key_q;
`endif

        if (frame_err) begin
            ext_d      = 1'b0;
            brk_d      = 1'b0;
            skip_d     = 1'b0;
            skip_cnt_d = '0;
        end else if (byte_vld) begin
            if (skip_q) begin
                skip_cnt_d = skip_cnt_q - 3'd1;
                if (skip_cnt_q == 3'd1) begin
                    skip_d = 1'b0;
                    ext_d  = 1'b0;
                    brk_d  = 1'b0;
                end
            end else begin
                case (shift_q)
                    8'hE0: ext_d = 1'b1;
                    8'hF0: brk_d = 1'b1;
                    8'hE1: begin
                        skip_d     = 1'b1;
                        skip_cnt_d = 3'd7;
                        ext_d      = 1'b0;
                        brk_d      = 1'b0;
                    end
                    default: begin
                        ext_d = 1'b0;
                        brk_d = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
                        if (!brk_q && tm_vld_q && tm_key_q == {ext_q, shift_q}) begin
                            strobe_d = 1'b0;
                        end else begin
                            key_d    = {~key_q[10], ~brk_q, ext_q, shift_q};
                            strobe_d = 1'b1;
                            if (!brk_q) begin
                                tm_vld_d = 1'b1;
                                tm_key_d = {ext_q, shift_q};
                            end else if (tm_vld_q && tm_key_q == {ext_q, shift_q}) begin
                                tm_vld_d = 1'b0;
                            end
                        end
`else
                        key_d    = {~key_q[10], ~brk_q, ext_q, shift_q};
                        strobe_d = 1'b1;
`endif
                    end
                endcase
            end
        end
    end

    always_ff @(posedge I_CLK_48M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_flt_q  <= 1'b1;
            dat_flt_q  <= 1'b1;
            clk_cnt_q  <= '0;
            dat_cnt_q  <= '0;
            clk_prev_q <= 1'b1;
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            par_err_q  <= 1'b0;
            to_cnt_q   <= '0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            skip_q     <= 1'b0;
            skip_cnt_q <= '0;
            key_q      <= '0;
            strobe_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], I_PS2_CLK};
            dat_sync_q <= {dat_sync_q[0], I_PS2_DAT};
            clk_flt_q  <= clk_flt_d;
            dat_flt_q  <= dat_flt_d;
            clk_cnt_q  <= clk_cnt_d;
            dat_cnt_q  <= dat_cnt_d;
            clk_prev_q <= clk_flt_q;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            par_err_q  <= par_err_d;
            to_cnt_q   <= to_cnt_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            skip_q     <= skip_d;
            skip_cnt_q <= skip_cnt_d;
            key_q      <= key_d;
            strobe_q   <= strobe_d;
            err_q      <= err_d;
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    always_ff @(posedge I_CLK_48M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            tm_vld_q <= 1'b0;
            tm_key_q <= '0;
        end else begin
            tm_vld_q <= tm_vld_d;
            tm_key_q <= tm_key_d;
        end
    end
`endif

    assign O_PS2_KEY = key_q;
    assign O_STROBE  = strobe_q;
    assign O_ERR     = err_q;

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Self-checking bench for ps2_key_encoder: directed test-plan frames plus random frames against a reference model.
module tb_ps2_key_encoder;

    localparam int TB_TO = 6000;
    localparam int H     = 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_dat = 1'b1;
    logic [10:0] key;
    logic        strobe;
    logic        err;

    ps2_key_encoder #(.FILTER_LEN(8), .TIMEOUT(TB_TO)) dut (
        .I_CLK_48M (clk),
        .I_RESETn  (rst_n),
        .I_PS2_CLK (ps2_clk),
        .I_PS2_DAT (ps2_dat),
        .O_PS2_KEY (key),
        .O_STROBE  (strobe),
        .O_ERR     (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int strb_cnt = 0, err_cnt = 0, both_cnt = 0, unstable_cnt = 0;
    logic [10:0] last_key = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            last_key <= key;
        end else begin
            if (strobe) strb_cnt <= strb_cnt + 1;
            if (err) err_cnt <= err_cnt + 1;
            if (strobe && err) both_cnt <= both_cnt + 1;
            if (key != last_key && !strobe) unstable_cnt <= unstable_cnt + 1;
            last_key <= key;
        end
    end

    // Reference model: event word and prefix state as a keyboard handler would track them.
    logic [10:0] m_key;
    bit          m_ext, m_brk, m_skip;
    int          m_skip_left;
    bit          m_tm_vld;
    logic [8:0]  m_tm_key;
    int          exp_s, exp_e;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mdl_reset();
        m_key = '0; m_ext = 0; m_brk = 0; m_skip = 0; m_skip_left = 0;
        m_tm_vld = 0; m_tm_key = '0;
    endtask

    task automatic mdl_frame(input logic [7:0] b, input bit bad);
        bit drop;
        exp_s = 0;
        exp_e = 0;
        if (bad) begin
            exp_e = 1;
            m_ext = 0; m_brk = 0; m_skip = 0; m_skip_left = 0;
        end else if (m_skip) begin
            m_skip_left--;
            if (m_skip_left == 0) begin
                m_skip = 0; m_ext = 0; m_brk = 0;
            end
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b == 8'hE1) begin
            m_skip = 1; m_skip_left = 7; m_ext = 0; m_brk = 0;
        end else begin
            drop = 0;
`ifdef PS2_TYPEMATIC_FILTER_EN
            if (!m_brk && m_tm_vld && m_tm_key == {m_ext, b}) drop = 1;
            else if (!m_brk) begin
                m_tm_vld = 1; m_tm_key = {m_ext, b};
            end else if (m_tm_vld && m_tm_key == {m_ext, b}) m_tm_vld = 0;
`endif
            if (!drop) begin
                m_key = {~m_key[10], ~m_brk, m_ext, b};
                exp_s = 1;
            end
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_bit(input logic v, input bit glitch);
        ps2_dat = v;
        wait_clk(H);
        ps2_clk = 1'b0;
        wait_clk(H);
        ps2_clk = 1'b1;
        if (glitch) begin
            wait_clk(4);
            ps2_clk = 1'b0;
            wait_clk(3);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit glitch);
        send_bit(1'b0, 0);
        for (int i = 0; i < 8; i++) send_bit(b[i], glitch && i == 3);
        send_bit((~^b) ^ bad_par, 0);
        send_bit(~bad_stop, 0);
        ps2_dat = 1'b1;
        wait_clk(H);
    endtask

    task automatic do_frame(input string tag, input logic [7:0] b, input bit bad_par,
                            input bit bad_stop, input bit glitch);
        int sb, eb;
        sb = strb_cnt;
        eb = err_cnt;
        send_frame(b, bad_par, bad_stop, glitch);
        wait_clk(40);
        mdl_frame(b, bad_par | bad_stop);
        chk({tag, "_strobes"}, 32'(strb_cnt - sb), 32'(exp_s));
        chk({tag, "_errs"}, 32'(err_cnt - eb), 32'(exp_e));
        chk({tag, "_key"}, 32'(key), 32'(m_key));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wait_clk(3);
        #1;
        chk("rst_key", 32'(key), 32'h0);
        chk("rst_strobe", 32'(strobe), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        rst_n = 1'b1;
        mdl_reset();
        wait_clk(20);
    endtask

    initial begin
        logic [7:0] b, lastb;
        int r, sb, eb, waited;
        bit bp, bs, gl;

        mdl_reset();
        wait_clk(2);
        do_reset();
        chk("post_rst_key", 32'(key), 32'h0);

        do_frame("make_1c", 8'h1C, 0, 0, 0);
        chk("tp_make_1c", 32'(key), 32'h61C);
        do_frame("f0_alone", 8'hF0, 0, 0, 0);
        do_frame("brk_1c", 8'h1C, 0, 0, 0);
        chk("tp_brk_1c", 32'(key), 32'h01C);
        do_frame("e0", 8'hE0, 0, 0, 0);
        do_frame("ext_6b", 8'h6B, 0, 0, 0);
        chk("tp_ext_6b", 32'(key), 32'h76B);
        do_frame("e0b", 8'hE0, 0, 0, 0);
        do_frame("f0b", 8'hF0, 0, 0, 0);
        do_frame("ext_brk_6b", 8'h6B, 0, 0, 0);
        chk("tp_ext_brk_6b", 32'(key), 32'h16B);
        do_frame("bad_par", 8'h1C, 1, 0, 0);
        do_frame("after_par", 8'h1C, 0, 0, 0);
        do_frame("bad_stop", 8'h2A, 0, 1, 0);
        do_frame("glitch", 8'h5A, 0, 0, 1);

        // Partial frame: start + 4 data bits, then the clock stops.
        sb = strb_cnt;
        eb = err_cnt;
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
        wait_clk(TB_TO - 50);
        chk("timeout_early", 32'(err_cnt - eb), 32'h0);
        waited = 0;
        while (err_cnt == eb && waited < 300) begin
            wait_clk(1);
            waited++;
        end
        wait_clk(5);
        chk("timeout_err", 32'(err_cnt - eb), 32'h1);
        chk("timeout_no_event", 32'(strb_cnt - sb), 32'h0);
        mdl_frame(8'h00, 1);
        do_frame("after_timeout", 8'h1C, 0, 0, 0);

        // Pause sequence is swallowed entirely.
        sb = strb_cnt;
        do_frame("pause_e1", 8'hE1, 0, 0, 0);
        do_frame("pause_14", 8'h14, 0, 0, 0);
        do_frame("pause_77", 8'h77, 0, 0, 0);
        do_frame("pause_e1b", 8'hE1, 0, 0, 0);
        do_frame("pause_f0", 8'hF0, 0, 0, 0);
        do_frame("pause_14b", 8'h14, 0, 0, 0);
        do_frame("pause_f0b", 8'hF0, 0, 0, 0);
        do_frame("pause_77b", 8'h77, 0, 0, 0);
        do_frame("pause_1c", 8'h1C, 0, 0, 0);
        chk("pause_total", 32'(strb_cnt - sb), 32'h1);

        lastb = 8'h1C;
        for (int i = 0; i < 70; i++) begin
            r = $urandom_range(0, 99);
            if (r < 12) b = 8'hE0;
            else if (r < 24) b = 8'hF0;
            else if (r < 27) b = 8'hE1;
            else if (r < 50) b = lastb;
            else b = 8'($urandom_range(0, 255));
            bp = ($urandom_range(0, 14) == 0);
            bs = ($urandom_range(0, 19) == 0);
            gl = ($urandom_range(0, 5) == 0);
            do_frame("rand", b, bp, bs, gl);
            if (b != 8'hE0 && b != 8'hF0 && b != 8'hE1) lastb = b;
        end

        // Reset in the middle of a frame restarts the toggle from 0.
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        do_reset();
        do_frame("after_rst", 8'h1C, 0, 0, 0);

        do_reset();
        do_frame("tm1", 8'h1C, 0, 0, 0);
        do_frame("tm2", 8'h1C, 0, 0, 0);
        do_frame("tm3", 8'h1C, 0, 0, 0);
        chk("tm_toggle", 32'(key[10]), 32'h1);

        chk("strobe_err_overlap", 32'(both_cnt), 32'h0);
        chk("key_stable", 32'(unstable_cnt), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
